// File: rtl/timer_pkg.sv
// Shared definitions for the timer register front-end: register map, field
// positions, mode encodings and the bus FSM state type.
package timer_pkg;

    localparam int REG_CTRL  = 'h0;
    localparam int REG_TERM  = 'h4;
    localparam int REG_STAT  = 'h8;
    localparam int REG_COUNT = 'hC;

    localparam int CTRL_START   = 0;
    localparam int CTRL_HALT    = 1;
    localparam int CTRL_MODE_LO = 2;
    localparam int CTRL_MODE_HI = 3;
    localparam int CTRL_IE      = 4;

    localparam int STAT_RUN  = 0;
    localparam int STAT_PEND = 1;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_FREERUN  = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } bus_state_e;

    // Word index of a byte offset; the low two address bits never select.
    function automatic int reg_word(input int offset);
        return offset >> 2;
    endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector: o_rise is high in the first cycle that
// i_sig is seen high after having been low.
module edge_detect_rise (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/timer_regs.sv
// CPU-facing register block for the timing counter: control pulses, mode and
// terminal count out; status, count and a sticky maskable interrupt back in.
module timer_regs
    import timer_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int MODE_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_valid,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_ready,
    output logic              ro_trig_start,
    output logic              ro_trig_halt,
    output logic [MODE_W-1:0] ro_mode,
    output logic [DATA_W-1:0] ro_termcount,
    input  logic              rf_status,
    input  logic [DATA_W-1:0] rf_currcount,
    input  logic              rf_int,
    output logic              irq
);

    // Handshake: the master raises bus_valid with we/addr/wdata stable and holds
    // it until bus_ready. A request seen in IDLE is accepted on that edge and
    // bus_ready pulses for exactly the following cycle with bus_rdata valid;
    // bus_valid is ignored during that response cycle.

    bus_state_e          r_state;
    bus_state_e          w_state_nxt;
    logic                w_accept;
    logic                w_wr;
    logic                w_rd;
    logic [ADDR_W-3:0]   w_idx;
    logic                w_sel_ctrl;
    logic                w_sel_term;
    logic                w_sel_stat;
    logic                w_sel_count;
    logic                w_start;
    logic                w_halt;
    logic                w_pend_clr;
    logic                w_int_rise;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                w_unused_addr_bits;

    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_term;
    logic [DATA_W-1:0]   r_termcount;
    logic [MODE_W-1:0]   r_mode;
    logic                r_ie;
    logic                r_pend;
    logic                r_irq;
    logic                r_trig_start;
    logic                r_trig_halt;

    // ---------------- bus FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- bus FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus_valid) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- bus FSM: outputs ----------------
    always_comb begin
        w_accept  = 1'b0;
        bus_ready = 1'b0;
        case (r_state)
            ST_IDLE: w_accept  = bus_valid;
            ST_RESP: bus_ready = 1'b1;
            default: ;
        endcase
    end

    // ---------------- address decode ----------------
    assign w_idx              = bus_addr[ADDR_W-1:2];
    assign w_unused_addr_bits = ^bus_addr[1:0];
    assign w_sel_ctrl  = (w_idx == (ADDR_W-2)'(reg_word(REG_CTRL)));
    assign w_sel_term  = (w_idx == (ADDR_W-2)'(reg_word(REG_TERM)));
    assign w_sel_stat  = (w_idx == (ADDR_W-2)'(reg_word(REG_STAT)));
    assign w_sel_count = (w_idx == (ADDR_W-2)'(reg_word(REG_COUNT)));

    assign w_wr = w_accept & bus_we;
    assign w_rd = w_accept & ~bus_we;

    // HALT dominates: a simultaneous START neither pulses nor reloads the count.
    assign w_halt     = w_wr & w_sel_ctrl & bus_wdata[CTRL_HALT];
    assign w_start    = w_wr & w_sel_ctrl & bus_wdata[CTRL_START] & ~bus_wdata[CTRL_HALT];
    assign w_pend_clr = w_wr & w_sel_stat & bus_wdata[STAT_PEND];

    edge_detect_rise u_int_edge (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_sig   (rf_int),
        .o_rise  (w_int_rise)
    );

    // ---------------- read mux ----------------
    always_comb begin
        w_rdata_nxt = '0;
        if (w_rd) begin
            if (w_sel_ctrl) begin
                w_rdata_nxt[CTRL_MODE_HI:CTRL_MODE_LO] = 2'(r_mode);
                w_rdata_nxt[CTRL_IE]                   = r_ie;
            end else if (w_sel_term) begin
                w_rdata_nxt = r_term;
            end else if (w_sel_stat) begin
                w_rdata_nxt[STAT_RUN]  = rf_status;
                w_rdata_nxt[STAT_PEND] = r_pend;
            end else if (w_sel_count) begin
                w_rdata_nxt = rf_currcount;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (w_accept) begin
            r_rdata <= w_rdata_nxt;
        end
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_term       <= '0;
            r_termcount  <= '0;
            r_mode       <= MODE_W'(MODE_ONESHOT);
            r_ie         <= 1'b0;
            r_trig_start <= 1'b0;
            r_trig_halt  <= 1'b0;
        end else begin
            r_trig_start <= w_start;
            r_trig_halt  <= w_halt;
            if (w_wr && w_sel_term) begin
                r_term <= bus_wdata;
            end
            if (w_wr && w_sel_ctrl) begin
                r_mode <= MODE_W'(bus_wdata[CTRL_MODE_HI:CTRL_MODE_LO]);
                r_ie   <= bus_wdata[CTRL_IE];
            end
            if (w_start) begin
                r_termcount <= r_term;
            end
        end
    end

    // ---------------- sticky pending flag and interrupt ----------------
    // A new terminal-count edge wins over a same-cycle software clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            if (w_int_rise) begin
                r_pend <= 1'b1;
            end else if (w_pend_clr) begin
                r_pend <= 1'b0;
            end
            r_irq <= r_pend & r_ie;
        end
    end

    assign bus_rdata     = r_rdata;
    assign ro_trig_start = r_trig_start;
    assign ro_trig_halt  = r_trig_halt;
    assign ro_mode       = r_mode;
    assign ro_termcount  = r_termcount;
    assign irq           = r_irq;

endmodule

// File: tb/tb_timer_regs.sv
// Self-checking bench for timer_regs: directed scenarios followed by random
// bus traffic, all compared against a transaction-level register model.
module tb_timer_regs;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int MODE_W = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              bus_valid = 1'b0;
    logic              bus_we = 1'b0;
    logic [ADDR_W-1:0] bus_addr = '0;
    logic [DATA_W-1:0] bus_wdata = '0;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ready;
    logic              ro_trig_start;
    logic              ro_trig_halt;
    logic [MODE_W-1:0] ro_mode;
    logic [DATA_W-1:0] ro_termcount;
    logic              rf_status = 1'b0;
    logic [DATA_W-1:0] rf_currcount = '0;
    logic              rf_int = 1'b0;
    logic              irq;

    always #5 clk = ~clk;

    timer_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MODE_W(MODE_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_valid     (bus_valid),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_ready     (bus_ready),
        .ro_trig_start (ro_trig_start),
        .ro_trig_halt  (ro_trig_halt),
        .ro_mode       (ro_mode),
        .ro_termcount  (ro_termcount),
        .rf_status     (rf_status),
        .rf_currcount  (rf_currcount),
        .rf_int        (rf_int),
        .irq           (irq)
    );

    // ---------------- scoreboard and model state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int n_start_seen = 0;
    int n_halt_seen = 0;
    logic [DATA_W-1:0] exp_q[$];

    logic [31:0] m_term;
    logic [31:0] m_termcount;
    logic [1:0]  m_mode;
    logic        m_ie;
    logic        m_pend;
    logic        m_int;
    int          m_starts = 0;
    int          m_halts = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (ro_trig_start) n_start_seen++;
            if (ro_trig_halt)  n_halt_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_term      = '0;
        m_termcount = '0;
        m_mode      = '0;
        m_ie        = 1'b0;
        m_pend      = 1'b0;
    endtask

    task automatic check_outputs_zero(input string phase);
        check({phase, "_rdata"},     bus_rdata, 0);
        check({phase, "_ready"},     bus_ready, 0);
        check({phase, "_start"},     ro_trig_start, 0);
        check({phase, "_halt"},      ro_trig_halt, 0);
        check({phase, "_mode"},      ro_mode, 0);
        check({phase, "_termcount"}, ro_termcount, 0);
        check({phase, "_irq"},       irq, 0);
    endtask

    // Changes the terminal-count event line; a 0->1 change marks an event.
    task automatic drive_int(input logic v);
        @(posedge clk); #1;
        if (v && !m_int) m_pend = 1'b1;
        m_int  = v;
        rf_int = v;
    endtask

    // One complete bus transaction. raise_int lifts rf_int in the same cycle
    // the request is presented, so its edge coincides with acceptance.
    task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                            input logic status, input logic [31:0] count_val,
                            input logic raise_int);
        logic [31:0] exp_rd;
        logic        rise;
        logic        exp_start_now;
        int          lat;
        @(posedge clk); #1;
        rise = raise_int && !m_int;
        case (addr[3:2])
            2'd0:    exp_rd = {27'b0, m_ie, m_mode, 2'b00};
            2'd1:    exp_rd = m_term;
            2'd2:    exp_rd = {30'b0, m_pend, status};
            default: exp_rd = count_val;
        endcase
        if (!we) exp_q.push_back(exp_rd);
        exp_start_now = 1'b0;
        if (we) begin
            case (addr[3:2])
                2'd0: begin
                    m_mode = wdata[3:2];
                    m_ie   = wdata[4];
                    if (wdata[1]) begin
                        m_halts++;
                    end else if (wdata[0]) begin
                        m_starts++;
                        m_termcount   = m_term;
                        exp_start_now = 1'b1;
                    end
                end
                2'd1: m_term = wdata;
                2'd2: if (wdata[1] && !rise) m_pend = 1'b0;
                default: ;
            endcase
        end
        if (rise) m_pend = 1'b1;
        if (raise_int) m_int = 1'b1;

        bus_valid    = 1'b1;
        bus_we       = we;
        bus_addr     = addr;
        bus_wdata    = wdata;
        rf_status    = status;
        rf_currcount = count_val;
        if (raise_int) rf_int = 1'b1;

        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            rf_currcount = count_val + 1;
        end while (!bus_ready && lat < 8);
        check("ready_latency", lat, 1);
        if (bus_ready) begin
            if (!we) check("rdata", bus_rdata, exp_q.pop_front());
            check("start_pulse", ro_trig_start, exp_start_now);
            check("termcount", ro_termcount, m_termcount);
            check("mode", ro_mode, m_mode);
        end else if (!we) begin
            void'(exp_q.pop_front());
        end
        bus_valid = 1'b0;
        @(posedge clk); #1;
        check("ready_one_cycle", bus_ready, 0);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
        check("irq", irq, m_pend & m_ie);
        check("start_count", n_start_seen, m_starts);
        check("halt_count", n_halt_seen, m_halts);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  r_addr;
        logic [31:0] r_wdata;
        logic        r_we;
        model_reset();
        m_int = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("por");
        @(posedge clk); #1;
        reset = 1'b1;

        // Load non-zero state so the mid-read reset has something to clear.
        bus_xfer(1'b1, 4'h4, 32'h0000_ABCD, 1'b0, 32'h0, 1'b0);
        bus_xfer(1'b1, 4'h0, 32'h0000_001D, 1'b0, 32'h0, 1'b0);
        drive_int(1'b1);
        drive_int(1'b0);
        settle();

        @(posedge clk); #1;
        bus_valid = 1'b1;
        bus_we    = 1'b0;
        bus_addr  = 4'h0;
        #3 reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("midrst");
        @(negedge clk);
        check("midrst_no_ready", bus_ready, 0);
        bus_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();

        bus_xfer(1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        bus_xfer(1'b0, 4'h8, 32'h0, 1'b0, 32'h0, 1'b0);
        settle();

        bus_xfer(1'b1, 4'h4, 32'h0000_0064, 1'b0, 32'h0, 1'b0);
        bus_xfer(1'b1, 4'h0, 32'h0000_0011, 1'b0, 32'h0, 1'b0);
        settle();
        bus_xfer(1'b0, 4'h8, 32'h0, 1'b1, 32'h0, 1'b0);
        bus_xfer(1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);

        bus_xfer(1'b1, 4'h0, 32'h0000_0003, 1'b0, 32'h0, 1'b0);
        settle();

        bus_xfer(1'b1, 4'h0, 32'h0000_0010, 1'b0, 32'h0, 1'b0);
        settle();
        drive_int(1'b1);
        @(posedge clk); #1;
        check("irq_lag", irq, 0);
        @(posedge clk); #1;
        check("irq_set", irq, 1);
        repeat (3) @(posedge clk);
        bus_xfer(1'b0, 4'h8, 32'h0, 1'b0, 32'h0, 1'b0);
        bus_xfer(1'b1, 4'h8, 32'h0000_0002, 1'b0, 32'h0, 1'b0);
        settle();
        drive_int(1'b0);
        settle();

        drive_int(1'b1);
        drive_int(1'b0);
        settle();
        bus_xfer(1'b1, 4'h8, 32'h0000_0002, 1'b0, 32'h0, 1'b1);
        settle();
        bus_xfer(1'b0, 4'h8, 32'h0, 1'b0, 32'h0, 1'b0);
        drive_int(1'b0);

        bus_xfer(1'b0, 4'hC, 32'h0, 1'b0, 32'h0000_1234, 1'b0);
        bus_xfer(1'b0, 4'h4, 32'h0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 2) == 0) drive_int(1'($urandom_range(0, 1)));
            r_addr  = 4'($urandom_range(0, 15));
            r_we    = 1'($urandom_range(0, 1));
            r_wdata = $urandom;
            bus_xfer(r_we, r_addr, r_wdata, 1'($urandom_range(0, 1)), $urandom,
                     ($urandom_range(0, 3) == 0));
            settle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
